// File: rtl/sorter_pkg.sv
// Shared definitions for the sorter sequencing controller: mode codes,
// FSM state type and per-mode group counts.
package sorter_pkg;

  localparam logic [1:0] M_QPSK  = 2'd0;
  localparam logic [1:0] M_QAM16 = 2'd1;

  localparam logic [2:0] GROUPS_QPSK  = 3'd1;
  localparam logic [2:0] GROUPS_QAM16 = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    HOLD
  } state_t;

  // Reserved mode codes fold onto QPSK so the sorter never sees them.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == M_QAM16) ? M_QAM16 : M_QPSK;
  endfunction

  function automatic logic [2:0] groups_for(input logic [1:0] m);
    return (m == M_QAM16) ? GROUPS_QAM16 : GROUPS_QPSK;
  endfunction

endpackage

// File: rtl/sorter_seq_buf.sv
// Four-slot capture register feeding the sorter; one slot written per
// enabled cycle, selected by a 2-bit slot index.
module sorter_seq_buf #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [1:0]       i_idx,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_d1,
  output logic [WIDTH-1:0] o_d2,
  output logic [WIDTH-1:0] o_d3,
  output logic [WIDTH-1:0] o_d4
);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      logic [WIDTH-1:0] r_q;
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_q <= '0;
        end else if (i_we && (i_idx == 2'(gi))) begin
          r_q <= i_data;
        end
      end
    end
  endgenerate

  assign o_d1 = g_slot[0].r_q;
  assign o_d2 = g_slot[1].r_q;
  assign o_d3 = g_slot[2].r_q;
  assign o_d4 = g_slot[3].r_q;

endmodule

// File: rtl/sorter_seq_ctrl.sv
// Collects sample groups of four, hands each group to the sorter and waits
// for completion. Optional WAIT watchdog enabled by SORTER_SEQ_TIMEOUT_EN.
module sorter_seq_ctrl
  import sorter_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] d4,
  output logic             srt_start,
  output logic [1:0]       srt_M,
  input  logic             srt_done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             err
);

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_slot;
  logic [1:0] r_mode;
  logic [2:0] r_grp;
  logic       w_accept;
  logic       w_last_grp;
  logic       w_timeout;
  logic [1:0] w_wr_idx;

  assign w_accept   = s_valid & s_ready;
  assign w_last_grp = (r_grp + 3'd1) >= groups_for(r_mode);
  // A frame always starts in slot 0, whatever the slot counter holds.
  assign w_wr_idx   = (r_state == IDLE) ? 2'd0 : r_slot;
  assign srt_M      = r_mode;

  always_comb begin
    w_state_next = r_state;
    s_ready      = 1'b0;
    srt_start    = 1'b0;
    res_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) w_state_next = LOAD;
      end
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid && (r_slot == 2'd3)) w_state_next = START;
      end
      START: begin
        srt_start    = 1'b1;
        w_state_next = WAIT;
      end
      WAIT: begin
        if (srt_done)       w_state_next = w_last_grp ? HOLD : LOAD;
        else if (w_timeout) w_state_next = IDLE;
      end
      HOLD: begin
        res_valid = 1'b1;
        if (res_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_slot  <= 2'd0;
      r_mode  <= M_QPSK;
      r_grp   <= 3'd0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) r_slot <= w_wr_idx + 2'd1;
      if ((r_state == IDLE) && w_accept) r_mode <= norm_mode(mode);
      if (r_state == IDLE) begin
        r_grp <= 3'd0;
      end else if ((r_state == WAIT) && srt_done) begin
        r_grp <= r_grp + 3'd1;
      end
    end
  end

  sorter_seq_buf #(.WIDTH(WIDTH)) u_buf (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_accept),
    .i_idx  (w_wr_idx),
    .i_data (s_data),
    .o_d1   (d1),
    .o_d2   (d2),
    .o_d3   (d3),
    .o_d4   (d4)
  );

`ifdef SORTER_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_wait_cnt;
  logic          r_err;

  // Counts consecutive WAIT cycles; any srt_done restarts the count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if ((r_state == WAIT) && !srt_done) r_wait_cnt <= r_wait_cnt + 1'b1;
      else                                r_wait_cnt <= '0;
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign w_timeout = (r_state == WAIT) && !srt_done && (r_wait_cnt == TW'(TIMEOUT - 1));
  assign err       = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
  assign w_timeout        = 1'b0;
  assign err              = 1'b0;
`endif

endmodule
